// File: rtl/wav_mcu_irq_fast_ctrl.sv
// Fast-interrupt conditioning: optional 2-flop sync, edge/level detect, sticky pending, clear and mask.
// Optional overflow status flops are built when WAV_MCU_IRQ_FAST_OVF_EN is defined.
module wav_mcu_irq_fast_ctrl #(
  parameter int unsigned NIRQ = 15
) (
  input  logic            i_hclk,
  input  logic            i_hreset_n,
  input  logic [NIRQ-1:0] i_irq,
  input  logic [NIRQ-1:0] i_clr_cfg,
  input  logic [NIRQ-1:0] i_sticky_cfg,
  input  logic [NIRQ-1:0] i_msk_cfg,
  input  logic [NIRQ-1:0] i_sync_cfg,
  input  logic [NIRQ-1:0] i_edge_cfg,
  output logic [NIRQ-1:0] o_irq_fast,
  output logic [NIRQ-1:0] o_irq_fast_sta,
  output logic [NIRQ-1:0] o_irq_fast_ovf
);

  logic [NIRQ-1:0] s1;
  logic [NIRQ-1:0] s2;
  logic [NIRQ-1:0] prev;
  logic [NIRQ-1:0] pend;
  logic [NIRQ-1:0] sel;
  logic [NIRQ-1:0] evt;

  always_comb begin
    sel = (i_sync_cfg & s2) | (~i_sync_cfg & i_irq);
    evt = (i_edge_cfg & sel & ~prev) | (~i_edge_cfg & sel);
  end

  // Synchronizer runs regardless of i_sync_cfg; clear only matters in sticky mode and never beats a new event.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      pend <= '0;
    end else begin
      s1   <= i_irq;
      s2   <= s1;
      prev <= sel;
      pend <= evt | (pend & i_sticky_cfg & ~i_clr_cfg);
    end
  end

  assign o_irq_fast     = pend & ~i_msk_cfg;
  assign o_irq_fast_sta = pend;

`ifdef WAV_MCU_IRQ_FAST_OVF_EN
  logic [NIRQ-1:0] ovf;

  // A clear in the same cycle as a new overflow acknowledges it, so clear dominates here.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf | (evt & pend & i_sticky_cfg)) & ~i_clr_cfg;
    end
  end

  assign o_irq_fast_ovf = ovf;
`else
  assign o_irq_fast_ovf = '0;
`endif

endmodule
